// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one single-ported data memory between
// port 0 (core MEM stage) and port 1 (debug/program loader).
// Latency: accept in T, memory strobe in T+1, response pulse in T+2+MEM_LATENCY.
// Backpressure: reqN_ready only in IDLE and only for the winning port; losers keep valid held.
// Ports: clk/rst (async, active-high); req0_*/rsp0_* and req1_*/rsp1_* requester sides;
//        mem_re/mem_we/mem_addr/mem_wdata/mem_rdata memory side; busy = FSM not in IDLE;
//        stat_grant0/stat_grant1/stat_conflict counters, built only when MEM_ARB_STATS_EN is
//        defined (otherwise tied to 0).
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int STATS_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic                   req0_we,
  input  logic [ADDR_WIDTH-1:0]  req0_addr,
  input  logic [DATA_WIDTH-1:0]  req0_wdata,
  output logic                   rsp0_valid,
  output logic [DATA_WIDTH-1:0]  rsp0_rdata,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic                   req1_we,
  input  logic [ADDR_WIDTH-1:0]  req1_addr,
  input  logic [DATA_WIDTH-1:0]  req1_wdata,
  output logic                   rsp1_valid,
  output logic [DATA_WIDTH-1:0]  rsp1_rdata,
  output logic                   mem_re,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   busy,
  output logic [STATS_WIDTH-1:0] stat_grant0,
  output logic [STATS_WIDTH-1:0] stat_grant1,
  output logic [STATS_WIDTH-1:0] stat_conflict
);

  if (MEM_LATENCY < 1) begin : g_lat_chk
    $error("mem_arbiter: MEM_LATENCY must be >= 1");
  end

  // The counter only has to hold MEM_LATENCY-1.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  id_q, id_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic any_vld, both_vld, win_id, idle;
  logic [DATA_WIDTH-1:0] cap_dat;

  assign idle     = (state_q == S_IDLE);
  assign any_vld  = req0_valid | req1_valid;
  assign both_vld = req0_valid & req1_valid;
  // On a tie the port that did not win last time goes; otherwise the lone requester wins.
  assign win_id   = both_vld ? ~last_grant_q : req1_valid;

  // Gated by rst so ready reads 0 while reset is held, even with valid asserted.
  assign req0_ready = ~rst & idle & req0_valid & ~win_id;
  assign req1_ready = ~rst & idle & req1_valid & win_id;

  // Writes return zero as their response data.
  assign cap_dat = we_q ? '0 : mem_rdata;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_vld) begin
          state_d      = S_ISSUE;
          id_d         = win_id;
          last_grant_d = win_id;
          we_d         = win_id ? req1_we    : req0_we;
          addr_d       = win_id ? req1_addr  : req0_addr;
          wdata_d      = win_id ? req1_wdata : req0_wdata;
        end
      end
      S_ISSUE: begin
        mem_re  = ~we_q;
        mem_we  = we_q;
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          // Captured straight into the per-port output register so the data
          // appears with the pulse and then holds until that port's next pulse.
          if (id_q) rsp1_rdata_d = cap_dat;
          else      rsp0_rdata_d = cap_dat;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        rsp0_valid = ~id_q;
        rsp1_valid = id_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  // The latch holds address/data steady through ISSUE and WAIT.
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign busy       = ~idle;

`ifdef MEM_ARB_STATS_EN
  logic [STATS_WIDTH-1:0] grant0_q, grant1_q, conflict_q;
  logic hs0, hs1, conflict;

  assign hs0      = req0_valid & req0_ready;
  assign hs1      = req1_valid & req1_ready;
  assign conflict = ~rst & idle & both_vld;

  // Saturating counters: stop at all-ones, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant0_q   <= '0;
      grant1_q   <= '0;
      conflict_q <= '0;
    end else begin
      if (hs0 && !(&grant0_q))        grant0_q   <= grant0_q + 1'b1;
      if (hs1 && !(&grant1_q))        grant1_q   <= grant1_q + 1'b1;
      if (conflict && !(&conflict_q)) conflict_q <= conflict_q + 1'b1;
    end
  end

  assign stat_grant0   = grant0_q;
  assign stat_grant1   = grant1_q;
  assign stat_conflict = conflict_q;
`else
  assign stat_grant0   = '0;
  assign stat_grant1   = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a cycle-accurate reference model.
// Latency: expectations are timed from the handshake cycle (strobe T+1, response T+2+LAT).
// Backpressure: requesters hold valid until ready; random drops of valid are exercised.
module tb_mem_arbiter;
  localparam int LAT  = 3;
  localparam int SW   = 3;
  localparam int MAXS = (1 << SW) - 1;
`ifdef MEM_ARB_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_we;
  logic [31:0] req0_addr, req0_wdata;
  logic        rsp0_valid;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [31:0] req1_addr, req1_wdata;
  logic        rsp1_valid;
  logic [31:0] rsp1_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;
  logic [SW-1:0] stat_grant0, stat_grant1, stat_conflict;

  mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT), .STATS_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy),
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct { bit port; logic [31:0] data; int cyc; } rsp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; int cyc; } stb_t;
  typedef struct { logic [31:0] addr; int cyc; } rd_t;

  rsp_t rsp_q[$];
  stb_t stb_q[$];
  rd_t  rd_q[$];

  logic [31:0] memarr [logic [31:0]];  // contents seen by the memory responder
  logic [31:0] refmem [logic [31:0]];  // reference model's view of memory

  bit acc0, acc1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int due);
    tests++;
    fails++;
    $display("FAIL %s: event due at cycle %0d never seen (cycle %0d)", name, due, cyc);
  endtask

  // ---------------- reference model: arbitration, ready, busy, stats ----------------
  initial begin : model
    bit lg, win, idle, we;
    int next_acc, g0, g1, cf;
    logic [31:0] a, d, rd;
    rsp_t r;
    stb_t s;
    lg = 1'b1; next_acc = 0; g0 = 0; g1 = 0; cf = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        lg = 1'b1; next_acc = 0; g0 = 0; g1 = 0; cf = 0;
        rsp_q.delete();
        stb_q.delete();
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp0_rdata", rsp0_rdata, 0);
        check("rst_rsp1_rdata", rsp1_rdata, 0);
        check("rst_mem_strobes", {mem_re, mem_we}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_stats", {stat_grant0, stat_grant1, stat_conflict}, 0);
      end else begin
        idle = (cyc >= next_acc);
        check("stat_grant0", stat_grant0, STATS_EN ? g0 : 0);
        check("stat_grant1", stat_grant1, STATS_EN ? g1 : 0);
        check("stat_conflict", stat_conflict, STATS_EN ? cf : 0);
        check("busy", busy, !idle);
        if (req0_valid && req1_valid) win = (lg == 1'b0);
        else if (req0_valid)          win = 1'b0;
        else                          win = 1'b1;
        check("req0_ready", req0_ready, idle && req0_valid && !win);
        check("req1_ready", req1_ready, idle && req1_valid && win);
        if (idle && req0_valid && req1_valid && cf < MAXS) cf++;
        if (idle && (req0_valid || req1_valid)) begin
          we = win ? req1_we : req0_we;
          a  = win ? req1_addr : req0_addr;
          d  = win ? req1_wdata : req0_wdata;
          rd = refmem.exists(a) ? refmem[a] : 32'h0;
          if (we) refmem[a] = d;
          s.we = we; s.addr = a; s.wdata = d; s.cyc = cyc + 1;
          stb_q.push_back(s);
          r.port = win; r.data = we ? 32'h0 : rd; r.cyc = cyc + 2 + LAT;
          rsp_q.push_back(r);
          lg = win;
          next_acc = cyc + 3 + LAT;
          if (!win && g0 < MAXS) g0++;
          if (win && g1 < MAXS)  g1++;
        end
      end
    end
  end

  // ---------------- monitor: responses and memory strobes ----------------
  initial begin : monitor
    logic [31:0] hold0, hold1;
    rsp_t r;
    stb_t s;
    hold0 = 0; hold1 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold0 = 0; hold1 = 0;
        continue;
      end
      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
        r = rsp_q.pop_front();
        fail_now("rsp_timeout", r.cyc);
        if (r.port) hold1 = r.data; else hold0 = r.data;
      end
      while (stb_q.size() > 0 && stb_q[0].cyc < cyc) begin
        s = stb_q.pop_front();
        fail_now("strobe_timeout", s.cyc);
      end
      if (rsp0_valid || rsp1_valid) begin
        check("rsp_both_ports", rsp0_valid & rsp1_valid, 0);
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", {rsp0_valid, rsp1_valid}, 0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_port", rsp1_valid, r.port);
          check("rsp_cycle", cyc, r.cyc);
          if (r.port) hold1 = r.data; else hold0 = r.data;
        end
      end
      check("rsp0_rdata", rsp0_rdata, hold0);
      check("rsp1_rdata", rsp1_rdata, hold1);
      if (mem_re || mem_we) begin
        check("strobe_both", mem_re & mem_we, 0);
        if (stb_q.size() == 0) begin
          check("strobe_unexpected", {mem_re, mem_we}, 0);
        end else begin
          s = stb_q.pop_front();
          check("strobe_we", mem_we, s.we);
          check("strobe_addr", mem_addr, s.addr);
          if (s.we) check("strobe_wdata", mem_wdata, s.wdata);
          check("strobe_cycle", cyc, s.cyc);
        end
      end
    end
  end

  // ---------------- memory: data valid exactly LAT cycles after the read strobe ----------------
  initial begin : memory
    rd_t e;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_q.delete();
        mem_rdata = $urandom;
        continue;
      end
      if (mem_we) memarr[mem_addr] = mem_wdata;
      if (mem_re) begin
        e.addr = mem_addr; e.cyc = cyc + LAT;
        rd_q.push_back(e);
      end
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) void'(rd_q.pop_front());
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        e = rd_q.pop_front();
        mem_rdata = memarr.exists(e.addr) ? memarr[e.addr] : 32'hBAD0_0000;
      end else begin
        mem_rdata = $urandom;  // garbage outside the capture cycle
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input bit p);
    logic [31:0] a;
    a = 32'(4 * $urandom_range(0, 15));
    if (p) begin
      req1_we = 1'($urandom_range(0, 1)); req1_addr = a; req1_wdata = $urandom;
    end else begin
      req0_we = 1'($urandom_range(0, 1)); req0_addr = a; req0_wdata = $urandom;
    end
  endtask

  task automatic send(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
    int n;
    bit got;
    if (p) begin req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d; end
    else   begin req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d; end
    n = 0;
    got = 0;
    while (!got && n < 50) begin
      step();
      got = p ? acc1 : acc0;
      n++;
    end
    check("send_accepted", got, 1);
    if (p) req1_valid = 0; else req0_valid = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || rsp_q.size() != 0) && n < 100) begin
      step();
      n++;
    end
    check("drain_pending", rsp_q.size(), 0);
  endtask

  initial begin : driver
    int n, hs;
    for (int i = 0; i < 16; i++) begin
      memarr[32'(4 * i)] = 32'hA500_0000 + 32'(i);
      refmem[32'(4 * i)] = 32'hA500_0000 + 32'(i);
    end
    memarr[32'h10] = 32'hDEADBEEF;
    refmem[32'h10] = 32'hDEADBEEF;

    rst = 1;
    req0_valid = 1; req0_we = 0; req0_addr = 32'h10; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
    repeat (3) step();
    req0_valid = 0;
    rst = 0;
    repeat (3) step();
    check("idle_busy", busy, 0);
    check("idle_strobes", {mem_re, mem_we}, 0);

    // Directed: port 0 read, port 1 write, read-back of the write.
    send(0, 0, 32'h10, 32'h0);
    wait_idle();
    send(1, 1, 32'h20, 32'h12345678);
    wait_idle();
    send(0, 0, 32'h20, 32'h0);
    wait_idle();

    // Both ports continuously valid for 6 transactions: strict alternation.
    new_req(0); new_req(1);
    req0_valid = 1; req1_valid = 1;
    hs = 0; n = 0;
    while (hs < 6 && n < 200) begin
      step();
      if (acc0) new_req(0);
      if (acc1) new_req(1);
      hs += int'(acc0) + int'(acc1);
      n++;
    end
    check("both_phase_handshakes", hs, 6);
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    step();
    check("conflict_after_both", stat_conflict, STATS_EN ? 6 : 0);

    // Reset while the FSM waits on memory: transaction is abandoned.
    send(0, 0, 32'h14, 32'h0);
    step();
    rst = 1;
    step();
    step();
    rst = 0;
    step();
    check("post_rst_busy", busy, 0);
    check("post_rst_strobes", {mem_re, mem_we}, 0);
    check("post_rst_rsp", {rsp0_valid, rsp1_valid}, 0);
    send(1, 0, 32'h14, 32'h0);
    wait_idle();

    // Randomized traffic with valid drops.
    for (int c = 0; c < 800; c++) begin
      step();
      if (req0_valid) begin
        if (acc0) begin req0_valid = 1'($urandom_range(0, 1)); new_req(0); end
        else if ($urandom_range(0, 15) == 0) req0_valid = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        req0_valid = 1; new_req(0);
      end
      if (req1_valid) begin
        if (acc1) begin req1_valid = 1'($urandom_range(0, 1)); new_req(1); end
        else if ($urandom_range(0, 15) == 0) req1_valid = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        req1_valid = 1; new_req(1);
      end
    end
    req0_valid = 0; req1_valid = 0;
    wait_idle();
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported data memory between two requesters.
  - Port 0: core load/store path (MEM stage).
  - Port 1: debug/program loader.
- Round-robin arbitration, one outstanding transaction, valid/ready request handshake, single-cycle response pulse.
- Sits between the core's MEM-stage access and the memory block; sequences memory read/write strobes and waits a fixed latency for read data.

Parameters:
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, memory data width.
- MEM_LATENCY, 1, cycles from the mem strobe cycle until mem_rdata is valid; must be >= 1, elaboration error otherwise.
- STATS_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_we  in  1  port 0 write (1) / read (0).
- req0_addr  in  ADDR_WIDTH  port 0 address.
- req0_wdata  in  DATA_WIDTH  port 0 write data.
- rsp0_valid  out  1  port 0 response pulse.
- rsp0_rdata  out  DATA_WIDTH  port 0 read data.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.
- stat_grant0  out  STATS_WIDTH  port 0 grant count.
- stat_grant1  out  STATS_WIDTH  port 1 grant count.
- stat_conflict  out  STATS_WIDTH  count of cycles where both requested in IDLE.

Behaviour:
- Reset:
  - FSM to IDLE; last_grant=1, so port 0 wins the first tie.
  - All outputs 0: mem_re, mem_we, mem_addr, mem_wdata, rsp*_valid, rsp*_rdata, req*_ready, busy, stats.
  - Reset mid-transaction abandons it; no response is issued.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Winner = the single valid port, or, if both are valid, the port != last_grant.
  - reqN_ready is combinational and is 1 only for the winner, only in IDLE.
  - On handshake: latch id, we, addr and wdata; set last_grant=id; go to ISSUE.
- ISSUE (1 cycle):
  - mem_re = !we, mem_we = we; mem_addr and mem_wdata driven from the latch.
  - Load latency counter with MEM_LATENCY-1; go to WAIT.
- WAIT (MEM_LATENCY cycles):
  - mem_addr stays held; strobes are 0.
  - Counter decrements each cycle. When it reaches 0, capture mem_rdata (reads) or 0 (writes), then go to RESP.
- RESP (1 cycle):
  - rsp<id>_valid=1 with rsp<id>_rdata = the captured value.
  - Other response port stays 0; go to IDLE.
- Timing:
  - Handshake in cycle T -> strobe in T+1 -> response in T+2+MEM_LATENCY.
  - Next acceptance no earlier than T+3+MEM_LATENCY.
- rspN_rdata holds its last value between pulses.
- Requesters hold valid and payload until ready. Dropping valid before ready is legal and creates no transaction.
- Valid asserted outside IDLE: ready stays 0 and the request waits.
- Simultaneous events:
  - Both valid in IDLE: strict alternation (0,1,0,1,...) while both stay valid.
  - A single valid port wins regardless of last_grant.
- No out-of-range handling of addresses; passed to memory unchanged.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - stat_grant0 / stat_grant1 increment on each handshake of that port.
  - stat_conflict increments on each IDLE cycle with both req*_valid=1.
  - All counters saturate at all-ones and clear only on rst.
- Undefined: counters are not built; the stat_* ports are tied to 0.

Test Plan:
- Reset then idle, no valids -> all outputs 0, busy=0; assert rst during WAIT -> FSM in IDLE next cycle, no rsp pulse, mem strobes 0.
- Port 0 read addr 0x10, memory returns 0xDEADBEEF, MEM_LATENCY=1: handshake T -> mem_re=1 with mem_addr=0x10 at T+1 -> rsp0_valid=1 and rsp0_rdata=0xDEADBEEF at T+3; rsp1_valid stays 0.
- Port 1 write addr 0x20 data 0x12345678 -> mem_we=1 for exactly one cycle with mem_addr=0x20, mem_wdata=0x12345678 -> rsp1_valid=1 with rsp1_rdata=0.
- Both ports continuously valid, 6 transactions -> grant order 0,1,0,1,0,1; each ready asserted only in IDLE; stat_conflict=6 with MEM_ARB_STATS_EN.
- MEM_LATENCY=3, read -> response exactly 5 cycles after handshake; mem_rdata changes before the capture cycle are not returned.
- MEM_ARB_STATS_EN with STATS_WIDTH=2, 5 port 0 grants -> stat_grant0 saturates at 3; without the macro -> all stat_* stay 0.
